// File: rtl/seven_segment_scan_cntrl.sv
// Seven-segment scan controller.
// Cycles a one-hot digit enable across NUM_DIGITS digits. Each digit is shown
// for REFRESH_DIV cycles and preceded by BLANK_CYCLES of blanking. New digit
// codes enter a shadow register through a load/ready handshake. They are
// committed to the display register only at the frame boundary, so a frame
// never mixes old and new values.
//
// Handshake: a load is accepted on any rising edge where load && ready is high.
// ready stays low from that acceptance until the next frame boundary commits
// the shadow register. Loads presented while ready is low are dropped.
//
// Optional build macro SEVEN_SEG_SCAN_DIM_EN adds a 3-bit 'bright' input. It
// shortens the lit part of each SHOW window to ((bright+1)*REFRESH_DIV)>>3
// cycles.
module seven_segment_scan_cntrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [3*NUM_DIGITS-1:0] load_data,
`ifdef SEVEN_SEG_SCAN_DIM_EN
  input  logic [2:0]              bright,
`endif
  output logic                    ready,
  output logic                    seg_a,
  output logic                    seg_b,
  output logic                    seg_c,
  output logic                    seg_d,
  output logic                    seg_e,
  output logic                    seg_f,
  output logic                    seg_g,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DW      = 3 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DW-1:0]     shadow, shadow_n;
  logic [DW-1:0]     display, display_n;
  logic              pending, pending_n;
  logic              boundary;
  logic [6:0]        seg_q, seg_n;
  logic [NUM_DIGITS-1:0] dig_en_n;
  logic [DW-1:0]     disp_shift;
  logic [2:0]        code;
`ifdef SEVEN_SEG_SCAN_DIM_EN
  logic [35:0]       dim_thr;
`endif

  // {a,b,c,d,e,f,g} pattern for a 3-bit code; 4..7 all show "E".
  function automatic logic [6:0] decode(input logic [2:0] c);
    case (c)
      3'd0:    decode = 7'b1111110;
      3'd1:    decode = 7'b0110000;
      3'd2:    decode = 7'b1101101;
      3'd3:    decode = 7'b1111001;
      default: decode = 7'b1001111;
    endcase
  endfunction

  // Next state, handshake and registered-output values.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt + CNT_W'(1);
    boundary  = 1'b0;
    shadow_n  = shadow;
    display_n = display;
    pending_n = pending;
    seg_n     = 7'b0;
    dig_en_n  = '0;
    code      = 3'd0;
    disp_shift = '0;
`ifdef SEVEN_SEG_SCAN_DIM_EN
    dim_thr   = '0;
`endif

    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == REFRESH_LAST) begin
          state_n  = ST_BLANK;
          cnt_n    = '0;
          boundary = (idx == IDX_LAST);
          idx_n    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase

    // Commit uses pending as registered before this edge. A capture on the
    // same edge therefore waits for the following boundary.
    if (boundary && pending) begin
      display_n = shadow;
      pending_n = 1'b0;
    end
    if (load && !pending) begin
      shadow_n  = load_data;
      pending_n = 1'b1;
    end

    if (state_n == ST_SHOW) begin
      dig_en_n   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n;
      disp_shift = display_n >> (3 * idx_n);
      code       = disp_shift[2:0];
      seg_n      = decode(code);
`ifdef SEVEN_SEG_SCAN_DIM_EN
      dim_thr = (36'({1'b0, bright} + 4'd1) * 36'(REFRESH_DIV)) >> 3;
      if (36'(cnt_n) >= dim_thr)
        seg_n = 7'b0;
`endif
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      display    <= '0;
      pending    <= 1'b0;
      seg_q      <= 7'b0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      display    <= display_n;
      pending    <= pending_n;
      seg_q      <= seg_n;
      dig_en     <= dig_en_n;
      frame_done <= boundary;
    end
  end

  assign ready = ~pending;
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;

endmodule

// File: tb/tb_seven_segment_scan_cntrl.sv
// Bench for seven_segment_scan_cntrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2 (40-cycle frame). The reference model tracks the cycle
// position inside the frame since the last reset and the committed codes.
// Expected outputs are derived arithmetically from that position.
module tb_seven_segment_scan_cntrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = BC + RD;
  localparam int FRAME = ND * SLOT;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [11:0] load_data = '0;
  logic [2:0]  bright = 3'd7;
  logic        ready, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, frame_done;
  logic [3:0]  dig_en;
  wire  [12:0] dut_vec;
  wire  [6:0]  dut_seg;

  always #5 clk = ~clk;

  seven_segment_scan_cntrl #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
`ifdef SEVEN_SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .ready(ready), .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g), .dig_en(dig_en),
    .frame_done(frame_done)
  );

  assign dut_seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  assign dut_vec = {ready, dut_seg, dig_en, frame_done};

  // ---------------- reference model ----------------
  int          p = 0;          // cycles since the last reset edge
  logic        m_pend = 1'b0;
  logic [11:0] m_shadow = '0;
  logic [11:0] m_disp = '0;
  logic [2:0]  m_bright = 3'd7;
  logic [6:0]  lut [8];

  int n_vec = 0;
  int n_bad = 0;

  task automatic model_step();
    logic acc;
    if (rst) begin
      p = 0; m_pend = 1'b0; m_shadow = '0; m_disp = '0;
    end else begin
      acc = load && !m_pend;
      if (((p + 1) % FRAME == 0) && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_shadow = load_data;
        m_pend   = 1'b1;
      end
      p = p + 1;
    end
    m_bright = bright;
  endtask

  function automatic logic [12:0] model_out();
    int slot, dg, w;
    logic [6:0]  s;
    logic [3:0]  d;
    logic [11:0] sh;
    s = '0; d = '0;
    slot = p % FRAME;
    dg   = slot / SLOT;
    w    = slot % SLOT;
    if (w >= BC) begin
      d  = 4'(1 << dg);
      sh = m_disp >> (3 * dg);
      s  = lut[sh[2:0]];
`ifdef SEVEN_SEG_SCAN_DIM_EN
      if ((w - BC) >= (((int'(m_bright) + 1) * RD) >> 3)) s = '0;
`endif
    end
    return {!m_pend, s, d, (p > 0 && slot == 0)};
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait budget expired at t=%0t", name, $time);
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_vec, model_out());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic advance_to(input int target, input int modulus);
    int n = 0;
    while ((p % modulus) != target && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout("advance");
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    tick();
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) timeout(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       rdy;
    logic       fd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    lut = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111};

    // Reset release: 2 blank cycles, 8 cycles of digit 0, 2 blank, digit 1.
    tbl[0] = '{1'b1, 4'b0000, 7'b0000000, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 7'b0000000, 1'b1, 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 4'b0001, 7'b1111110, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 7'b0000000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 7'b0000000, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, 7'b1111110, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      tick();
      check("table", dut_vec, {tbl[i].rdy, tbl[i].seg, tbl[i].dig, tbl[i].fd});
    end

    // Load accepted -> ready low next cycle.
    load = 1'b1; load_data = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    load = 1'b0;
    check("load_ready_low", 13'(ready), 13'(0));

    // Second load while not ready is dropped.
    load = 1'b1; load_data = 12'hFFF;
    tick();
    load = 1'b0;
    check("ignored_load_ready", 13'(ready), 13'(0));

    // Commit at the boundary, ready back high in the first blank cycle.
    wait_frame_done("first_boundary");
    check("commit_ready", 13'(ready), 13'(1));
    ticks(2);
    check("frame_d0", {dut_seg, dig_en}, {7'b1111110, 4'b0001});
    ticks(SLOT);
    check("frame_d1", {dut_seg, dig_en}, {7'b0110000, 4'b0010});
    ticks(SLOT);
    check("frame_d2", {dut_seg, dig_en}, {7'b1101101, 4'b0100});
    ticks(SLOT);
    check("frame_d3", {dut_seg, dig_en}, {7'b1111001, 4'b1000});

    // Load accepted on the boundary edge: commit deferred a full frame.
    advance_to(FRAME - 1, FRAME);
    load = 1'b1; load_data = {3'd3, 3'd3, 3'd3, 3'd3};
    tick();
    load = 1'b0;
    check("bnd_load_fd_ready", {frame_done, ready}, 13'b10);
    ticks(2);
    check("bnd_load_old_d0", {dut_seg, dig_en}, {7'b1111110, 4'b0001});
    wait_frame_done("deferred_boundary");
    check("deferred_ready", 13'(ready), 13'(1));
    ticks(2);
    check("deferred_new_d0", {dut_seg, dig_en}, {7'b1111001, 4'b0001});

    // Reset during SHOW of digit 2 with a load pending.
    load = 1'b1; load_data = {3'd1, 3'd1, 3'd1, 3'd1};
    tick();
    load = 1'b0;
    advance_to(2 * SLOT + BC + 2, FRAME);
    check("pre_rst_d2", 13'(dig_en), 13'(4'b0100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", dut_vec, {1'b1, 7'b0, 4'b0, 1'b0});
    ticks(2);
    check("rst_restart_d0", {dut_seg, dig_en}, {7'b1111110, 4'b0001});
    wait_frame_done("rst_boundary");
    ticks(2);
    check("rst_discarded", {dut_seg, dig_en}, {7'b1111110, 4'b0001});

`ifdef SEVEN_SEG_SCAN_DIM_EN
    // Dimming: bright=1 lights the first 2 of 8 SHOW cycles.
    bright = 3'd1;
    advance_to(BC - 1, SLOT);
    for (int k = 0; k < RD; k++) begin
      tick();
      check("dim_seg", 13'(dut_seg), 13'((k < 2) ? 7'b1111110 : 7'b0));
      check("dim_dig", 13'(dig_en != 4'b0), 13'(1));
    end
    bright = 3'd7;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      load      = ($urandom_range(0, 3) == 0);
      load_data = 12'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
`ifdef SEVEN_SEG_SCAN_DIM_EN
      bright    = 3'($urandom_range(0, 7));
`endif
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
